// File: rtl/async_evt_pkg.sv
// Shared types for the async event arbiter: FSM state encoding and index-width helper.
package async_evt_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        OFFER
    } state_e;

    function automatic int ch_idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/async_event_arbiter_evt_rr_pick.sv
// Combinational round-robin picker: first requester strictly after `last`, wrapping to 0.
module evt_rr_pick
    import async_evt_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = ch_idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic [IDX_W-1:0]  grant,
    output logic              any
);

    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant = '0;
        any   = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            sum = {1'b0, last} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_CH)) begin
                sum = sum - (IDX_W+1)'(NUM_CH);
            end
            cand = sum[IDX_W-1:0];
            if (!any && req[cand]) begin
                grant = cand;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/async_event_arbiter.sv
// Synchronises NUM_CH async levels, latches their edges and serialises them round-robin
// onto a valid/ready port. Optional per-event timestamps: define ASYNC_EVT_TIMESTAMP_EN.
module async_event_arbiter
    import async_evt_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TS_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             sig_a,
    input  logic [NUM_CH-1:0]             ch_en,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [ch_idx_w(NUM_CH)-1:0]   evt_id,
    output logic                          evt_pol,
    output logic [NUM_CH-1:0]             overflow,
`ifdef ASYNC_EVT_TIMESTAMP_EN
    output logic [TS_W-1:0]               evt_ts,
`endif
    input  logic [NUM_CH-1:0]             ovf_clr
);

    localparam int IDX_W  = ch_idx_w(NUM_CH);
    localparam int INIT_W = $clog2(SYNC_STAGES);

    if (NUM_CH < 2 || NUM_CH > 16 || SYNC_STAGES < 2 || TS_W < 1) begin : g_bad_param
        $error("async_event_arbiter: parameter out of range");
    end

    state_e                               state_q, state_d;
    logic [INIT_W-1:0]                    init_cnt_q, init_cnt_d;
    logic [NUM_CH-1:0][SYNC_STAGES-1:0]   sync_q, sync_d;
    logic [NUM_CH-1:0]                    pending_q, pending_d;
    logic [NUM_CH-1:0]                    pend_pol_q, pend_pol_d;
    logic [NUM_CH-1:0]                    overflow_q, overflow_d;
    logic                                 evt_valid_q, evt_valid_d;
    logic [IDX_W-1:0]                     evt_id_q, evt_id_d;
    logic                                 evt_pol_q, evt_pol_d;
    logic [IDX_W-1:0]                     last_q, last_d;

    logic [NUM_CH-1:0] edge_v, pol_v, clr_v, ovf_set;
    logic              handshake;
    logic [IDX_W-1:0]  pick_grant;
    logic              pick_any;

`ifdef ASYNC_EVT_TIMESTAMP_EN
    logic [TS_W-1:0]              ts_cnt_q, ts_cnt_d;
    logic [NUM_CH-1:0][TS_W-1:0]  ch_ts_q, ch_ts_d;
    logic [TS_W-1:0]              evt_ts_q, evt_ts_d;
`endif

    evt_rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req   (pending_q),
        .last  (last_q),
        .grant (pick_grant),
        .any   (pick_any)
    );

    assign handshake = (state_q == OFFER) && evt_valid_q && evt_ready;

    // Synchroniser shift, edge detection and pending/overflow bookkeeping.
    always_comb begin
        sync_d     = sync_q;
        pending_d  = pending_q;
        pend_pol_d = pend_pol_q;
        edge_v     = '0;
        pol_v      = '0;
        clr_v      = '0;
        ovf_set    = '0;
`ifdef ASYNC_EVT_TIMESTAMP_EN
        ts_cnt_d   = ts_cnt_q + TS_W'(1);
        ch_ts_d    = ch_ts_q;
`endif
        if (handshake) begin
            clr_v[evt_id_q] = 1'b1;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            sync_d[c] = {sync_q[c][SYNC_STAGES-2:0], sig_a[c]};
            pol_v[c]  = sync_q[c][SYNC_STAGES-2];
            edge_v[c] = ch_en[c] && (state_q != INIT)
                        && (sync_q[c][SYNC_STAGES-1] ^ sync_q[c][SYNC_STAGES-2]);
            if (edge_v[c]) begin
                // A channel being drained this cycle takes the new edge instead of overflowing.
                if (pending_q[c] && !clr_v[c]) begin
                    ovf_set[c] = 1'b1;
                end else begin
                    pending_d[c]  = 1'b1;
                    pend_pol_d[c] = pol_v[c];
`ifdef ASYNC_EVT_TIMESTAMP_EN
                    ch_ts_d[c]    = ts_cnt_q;
`endif
                end
            end else if (clr_v[c]) begin
                pending_d[c] = 1'b0;
            end
        end
        overflow_d = (overflow_q & ~ovf_clr) | ovf_set;
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        evt_pol_d   = evt_pol_q;
        last_d      = last_q;
`ifdef ASYNC_EVT_TIMESTAMP_EN
        evt_ts_d    = evt_ts_q;
`endif
        unique case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + INIT_W'(1);
                if (init_cnt_q == INIT_W'(SYNC_STAGES - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (pick_any) begin
                    evt_id_d    = pick_grant;
                    evt_pol_d   = pend_pol_q[pick_grant];
`ifdef ASYNC_EVT_TIMESTAMP_EN
                    evt_ts_d    = ch_ts_q[pick_grant];
`endif
                    evt_valid_d = 1'b1;
                    state_d     = OFFER;
                end
            end
            OFFER: begin
                if (handshake) begin
                    last_d      = evt_id_q;
                    evt_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            sync_q      <= '0;
            pending_q   <= '0;
            pend_pol_q  <= '0;
            overflow_q  <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_pol_q   <= 1'b0;
            last_q      <= IDX_W'(NUM_CH - 1);
`ifdef ASYNC_EVT_TIMESTAMP_EN
            ts_cnt_q    <= '0;
            ch_ts_q     <= '0;
            evt_ts_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            sync_q      <= sync_d;
            pending_q   <= pending_d;
            pend_pol_q  <= pend_pol_d;
            overflow_q  <= overflow_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            evt_pol_q   <= evt_pol_d;
            last_q      <= last_d;
`ifdef ASYNC_EVT_TIMESTAMP_EN
            ts_cnt_q    <= ts_cnt_d;
            ch_ts_q     <= ch_ts_d;
            evt_ts_q    <= evt_ts_d;
`endif
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign evt_pol   = evt_pol_q;
    assign overflow  = overflow_q;
`ifdef ASYNC_EVT_TIMESTAMP_EN
    assign evt_ts    = evt_ts_q;
`endif

endmodule
